// File: rtl/cpu_debug_pkg.sv
// cpu_debug_pkg: command/status codes and FSM states shared by the debug bridge
package cpu_debug_pkg;
  localparam logic [7:0] CMD_READ = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] STATUS_OK = 8'h4B;
  localparam logic [7:0] STATUS_TIMEOUT = 8'hEE;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} e_dbg_state;
endpackage

// File: rtl/cpu_debug_bridge.sv
// cpu_debug_bridge: byte-stream host debug initiator issuing single 32-bit bus reads/writes
module cpu_debug_bridge
  import cpu_debug_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        req,
  input  logic        ack,
  output logic [3:0]  wmask,
  output logic [31:0] address,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy
);
  e_dbg_state state, state_nx;
  logic op_wr, ok;
  logic [1:0] bidx;
  logic [2:0] tidx, last_idx;
  logic [15:0] cnt;
  logic [31:0] addr_sr, rdata_q, rsh;
  logic rx_fire, tx_fire;
  // rx_ready is gated by rst so it reads low while reset is held
  assign rx_ready = !rst && (state == IDLE || state == ADDR || state == DATA);
  assign rx_fire = rx_valid && rx_ready;
  assign tx_valid = state == RESP;
  assign tx_fire = tx_valid && tx_ready;
  assign req = state == BUS;
  assign busy = state != IDLE;
  assign wmask = {4{req && op_wr}};
  assign address = {addr_sr[31:2], 2'b00};
  assign last_idx = (!op_wr && ok) ? 3'd4 : 3'd0;
  assign rsh = rdata_q << {tidx - 3'd1, 3'b000};
  assign tx_data = !tx_valid ? 8'h00 : (tidx == 3'd0) ? (ok ? STATUS_OK : STATUS_TIMEOUT) : rsh[31:24];
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = (rx_fire && (rx_data == CMD_READ || rx_data == CMD_WRITE)) ? ADDR : IDLE;
      ADDR: state_nx = (rx_fire && bidx == 2'd3) ? (op_wr ? DATA : BUS) : ADDR;
      DATA: state_nx = (rx_fire && bidx == 2'd3) ? BUS : DATA;
      BUS:  state_nx = (ack || cnt == 16'(TIMEOUT - 1)) ? RESP : BUS;
      RESP: state_nx = (tx_fire && tidx == last_idx) ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_wr <= 1'b0;
      ok <= 1'b0;
      bidx <= 2'd0;
      tidx <= 3'd0;
      cnt <= 16'd0;
      addr_sr <= 32'd0;
      wdata <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state <= state_nx;
      if (rx_fire && state == IDLE && state_nx == ADDR) op_wr <= rx_data == CMD_WRITE;
      if (rx_fire && state != IDLE) bidx <= bidx + 2'd1;
      if (rx_fire && state == ADDR) addr_sr <= {addr_sr[23:0], rx_data};
      if (rx_fire && state == DATA) wdata <= {wdata[23:0], rx_data};
      cnt <= (state == BUS) ? cnt + 16'd1 : 16'd0;
      // ok tracks ack every BUS cycle; the value on leaving BUS is the status
      if (state == BUS) ok <= ack;
      if (state == BUS && ack) rdata_q <= rdata;
      if (tx_fire) tidx <= (tidx == last_idx) ? 3'd0 : tidx + 3'd1;
    end
  end
endmodule

// File: tb/tb_cpu_debug_bridge.sv
// tb_cpu_debug_bridge: randomized transactions against a response-level reference model
module tb_cpu_debug_bridge;
  localparam int TO = 8;
  logic clk = 0, rst = 1, rx_valid = 0, tx_ready = 0, ack = 0;
  logic [7:0] rx_data = 0;
  logic [31:0] rdata = 0;
  logic rx_ready, tx_valid, req, busy;
  logic [7:0] tx_data;
  logic [3:0] wmask;
  logic [31:0] address, wdata;
  int n_tests = 0, n_fail = 0, stall = 0;
  bit stall_req = 0, bp_rand = 0, held_v = 0;
  logic [7:0] held_d = 0;
  logic [7:0] tx_q[$];

  cpu_debug_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .req(req), .ack(ack),
    .wmask(wmask), .address(address), .wdata(wdata), .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // sink: drives tx_ready, collects accepted bytes, verifies held bytes stay put
  always @(negedge clk) begin
    tx_ready = (stall > 0) ? 1'b0 : (bp_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    if (stall > 0) stall--;
    #1;
    if (rst) held_v = 0;
    else begin
      if (held_v) begin
        check("tx_hold_valid", tx_valid, 1);
        check("tx_hold_data", tx_data, held_d);
      end
      if (tx_valid && tx_ready) begin
        tx_q.push_back(tx_data);
        if (stall_req) begin stall = 10; stall_req = 0; end
      end
      held_v = tx_valid && !tx_ready;
      held_d = tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1;
    rx_data = b;
    while (!rx_ready && n < 50) begin @(negedge clk); n++; end
    check("rx_accept", rx_ready, 1);
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic do_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input int delay);
    logic [7:0] exp_q[$];
    logic [31:0] aa;
    int k;
    bit ok;
    tx_q.delete();
    send_byte(wr ? 8'h57 : 8'h52);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
    if (wr) for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
    aa = a & 32'hFFFF_FFFC;
    check("req_rise", req, 1);
    check("address", address, aa);
    check("wmask", wmask, wr ? 32'hF : 32'h0);
    if (wr) check("wdata", wdata, d);
    check("rx_blocked", rx_ready, 0);
    k = 0;
    while (req && k < 100) begin
      check("addr_stable", address, aa);
      ack = (k == delay);
      rdata = rd;
      @(negedge clk);
      k++;
    end
    ack = 0;
    rdata = $urandom;
    ok = delay < TO;
    check("req_cycles", k, ok ? delay + 1 : TO);
    check("req_drop", req, 0);
    check("resp_valid", tx_valid, 1);
    exp_q.push_back(ok ? 8'h4B : 8'hEE);
    if (ok && !wr) for (int i = 3; i >= 0; i--) exp_q.push_back(rd[8*i +: 8]);
    for (int i = 0; i < 300 && !(tx_q.size() >= exp_q.size() && !busy); i++) begin
      @(negedge clk);
      #2;
    end
    check("resp_len", tx_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < tx_q.size()) check("resp_byte", tx_q[i], exp_q[i]);
    check("idle_busy", busy, 0);
    check("idle_rx_ready", rx_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] g;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rx_ready", rx_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_req", req, 0);
    check("rst_wmask", wmask, 0);
    check("rst_address", address, 0);
    check("rst_wdata", wdata, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    #1;
    check("rel_rx_ready", rx_ready, 1);
    do_cmd(0, 32'h0000_0104, 0, 32'hDEAD_BEEF, 2);
    do_cmd(1, 32'h0000_0010, 32'h1234_5678, 0, 1);
    do_cmd(0, 32'h0000_2000, 0, 32'h0000_0001, 100);
    do_cmd(0, 32'h0000_2004, 0, 32'h5555_AAAA, 0);
    do_cmd(0, 32'h0000_0007, 0, 32'hCAFE_F00D, TO - 1);
    tx_q.delete();
    send_byte(8'h00);
    send_byte(8'hFF);
    repeat (3) @(negedge clk);
    #2;
    check("garbage_busy", busy, 0);
    check("garbage_silent", tx_q.size(), 0);
    do_cmd(0, 32'h8000_0020, 0, 32'h0BAD_CAFE, 4);
    stall_req = 1;
    do_cmd(0, 32'h0000_0040, 0, 32'hA5A5_5A5A, 0);
    bp_rand = 1;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        g = 8'($urandom);
        if (g == 8'h52 || g == 8'h57) g = 8'h00;
        send_byte(g);
      end
      do_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom_range(0, 10));
    end
    bp_rand = 0;
    tx_q.delete();
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) send_byte(8'h11);
    check("mid_req", req, 1);
    #2 rst = 1;
    #1;
    check("async_req_drop", req, 0);
    check("async_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_rx_ready", rx_ready, 1);
    repeat (20) @(negedge clk);
    #2;
    check("post_rst_silent", tx_q.size(), 0);
    do_cmd(1, 32'h0000_00F0, 32'h8765_4321, 0, 3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
